// File: rtl/mc_core_hs.sv
// mc_core_hs: multicycle MIPS-subset CPU tile. A single memory port with a
// req/ack handshake carries both instruction fetches and lw/sw data. A
// two-process control FSM sequences the datapath. Illegal opcodes and
// misaligned data accesses park the core in a sticky TRAP state.
module mc_core_hs #(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter int          ADDR_W           = 32,
  parameter bit          TRAP_ON_MISALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              retire,
  output logic              trap,
  output logic [31:0]       pc_dbg
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXR    = 4'd2,
    S_WBR    = 4'd3,
    S_EXI    = 4'd4,
    S_WBI    = 4'd5,
    S_MADR   = 4'd6,
    S_MRD    = 4'd7,
    S_WBM    = 4'd8,
    S_MWR    = 4'd9,
    S_BR     = 4'd10,
    S_JMP    = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_aluout;
  logic [31:0] r_mdr;
  logic [31:0] r_rf [0:31];

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_sext;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_target;
  logic [31:0] w_jmp_target;
  logic [31:0] w_addr_calc;
  logic        w_misalign;
  logic        w_funct_ok;
  logic        w_br_take;
  logic [31:0] w_data_addr;
  logic [31:0] w_addr_full;

  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata;

  // R-type ALU; slt compares as two's complement, everything else wraps.
  function automatic logic [31:0] alu_r(input logic [31:0] a, input logic [31:0] b,
                                        input logic [5:0] fn);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (fn)
      FN_ADD:  alu_r = a + b;
      FN_SUB:  alu_r = a - b;
      FN_AND:  alu_r = a & b;
      FN_OR:   alu_r = a | b;
      FN_SLT:  alu_r = (sa < sb) ? 32'd1 : 32'd0;
      default: alu_r = 32'd0;
    endcase
  endfunction

  // Instruction fields and derived values.
  assign w_op    = r_ir[31:26];
  assign w_rs    = r_ir[25:21];
  assign w_rt    = r_ir[20:16];
  assign w_rd    = r_ir[15:11];
  assign w_funct = r_ir[5:0];
  assign w_sext  = {{16{r_ir[15]}}, r_ir[15:0]};

  // r0 is hardwired to zero on read as well as suppressed on write.
  assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];

  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_br_target  = r_pc + {w_sext[29:0], 2'b00};
  assign w_jmp_target = {r_pc[31:28], r_ir[25:0], 2'b00};
  assign w_addr_calc  = r_a + w_sext;
  assign w_misalign   = |w_addr_calc[1:0];

  assign w_funct_ok = (w_funct == FN_ADD) || (w_funct == FN_SUB) ||
                      (w_funct == FN_AND) || (w_funct == FN_OR)  ||
                      (w_funct == FN_SLT);

  assign w_br_take = ((w_op == OP_BEQ) && (r_a == r_b)) ||
                     ((w_op == OP_BNE) && (r_a != r_b));

  // When misalignment does not trap, data accesses are word-aligned by
  // clearing the low address bits instead.
  assign w_data_addr = TRAP_ON_MISALIGN ? r_aluout : {r_aluout[31:2], 2'b00};
  assign w_addr_full = (r_state == S_FETCH) ? r_pc : w_data_addr;

  assign mem_addr  = w_addr_full[ADDR_W-1:0];
  assign mem_wdata = r_b;
  assign pc_dbg    = r_pc;

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode, handshake outputs and register-file write port.
  always_comb begin
    w_state_nxt = r_state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    retire      = 1'b0;
    trap        = 1'b0;
    w_rf_we     = 1'b0;
    w_rf_waddr  = w_rt;
    w_rf_wdata  = r_aluout;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (w_op)
          OP_RTYPE:      w_state_nxt = w_funct_ok ? S_EXR : S_TRAP;
          OP_ADDI:       w_state_nxt = S_EXI;
          OP_LW, OP_SW:  w_state_nxt = S_MADR;
          OP_BEQ, OP_BNE: w_state_nxt = S_BR;
          OP_J, OP_JAL:  w_state_nxt = S_JMP;
          default:       w_state_nxt = S_TRAP;
        endcase
      end
      S_EXR: w_state_nxt = S_WBR;
      S_WBR: begin
        w_rf_we     = 1'b1;
        w_rf_waddr  = w_rd;
        retire      = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_EXI: w_state_nxt = S_WBI;
      S_WBI: begin
        w_rf_we     = 1'b1;
        retire      = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_MADR: begin
        if (w_misalign && TRAP_ON_MISALIGN) begin
          w_state_nxt = S_TRAP;
        end else if (w_op == OP_LW) begin
          w_state_nxt = S_MRD;
        end else begin
          w_state_nxt = S_MWR;
        end
      end
      S_MRD: begin
        mem_req = 1'b1;
        if (mem_ack) w_state_nxt = S_WBM;
      end
      S_WBM: begin
        w_rf_we     = 1'b1;
        w_rf_wdata  = r_mdr;
        retire      = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_MWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          retire      = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_BR: begin
        retire      = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_JMP: begin
        if (w_op == OP_JAL) begin
          w_rf_we    = 1'b1;
          w_rf_waddr = 5'd31;
          w_rf_wdata = r_pc;
        end
        retire      = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: w_state_nxt = S_TRAP;
    endcase
    if (w_rf_waddr == 5'd0) w_rf_we = 1'b0;
    // Reset must silence the bus and the retire strobe immediately.
    if (!rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      retire  = 1'b0;
    end
  end

  // Datapath registers: PC, IR, operand latches, ALU result and memory data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc     <= RESET_PC;
      r_ir     <= 32'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_aluout <= 32'd0;
      r_mdr    <= 32'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ack) begin
            r_ir <= mem_rdata;
            r_pc <= w_pc_plus4;
          end
        end
        S_DECODE: begin
          r_a      <= w_rs_val;
          r_b      <= w_rt_val;
          r_aluout <= w_br_target;
        end
        S_EXR:         r_aluout <= alu_r(r_a, r_b, w_funct);
        S_EXI, S_MADR: r_aluout <= w_addr_calc;
        S_MRD: begin
          if (mem_ack) r_mdr <= mem_rdata;
        end
        S_BR: begin
          if (w_br_take) r_pc <= r_aluout;
        end
        S_JMP:   r_pc <= w_jmp_target;
        default: ;
      endcase
    end
  end

  // Register file: one synchronous write port, cleared on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= 32'd0;
    end else if (w_rf_we) begin
      r_rf[w_rf_waddr] <= w_rf_wdata;
    end
  end

endmodule

// File: tb/tb_mc_core_hs.sv
// tb_mc_core_hs: directed and random programs for mc_core_hs against an
// instruction-level reference model with a wait-state memory responder.
module tb_mc_core_hs;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic        retire;
  logic        trap;
  logic [31:0] pc_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ret = 0;
  int last_cyc = 0;

  logic [31:0] dmem [0:1023];
  logic [31:0] mmem [0:1023];
  logic [31:0] mr [0:31];
  logic [31:0] mpc = 32'd0;

  int          wait_cfg = 0;
  int          wcnt = 0;
  logic        pend = 1'b0;
  logic [31:0] h_addr = 32'd0;
  logic [31:0] h_wd = 32'd0;
  logic        h_we = 1'b0;

  mc_core_hs #(.RESET_PC(32'h0), .ADDR_W(32), .TRAP_ON_MISALIGN(1'b1)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .retire(retire), .trap(trap), .pc_dbg(pc_dbg));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks after wait_cfg idle cycles, checks request hold.
  always @(negedge clk) begin
    if (!rst || !mem_req) begin
      mem_ack = 1'b0;
      wcnt    = 0;
      pend    = 1'b0;
    end else begin
      if (pend) begin
        chk("hold_addr", mem_addr, h_addr);
        chk("hold_we", 32'(mem_we), 32'(h_we));
        if (mem_we) chk("hold_wdata", mem_wdata, h_wd);
      end
      if (mem_ack) wcnt = 0;
      if (wcnt >= wait_cfg) begin
        mem_ack   = 1'b1;
        mem_rdata = dmem[mem_addr[11:2]];
        if (mem_we) dmem[mem_addr[11:2]] = mem_wdata;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        wcnt++;
      end
      pend   = !mem_ack;
      h_addr = mem_addr;
      h_wd   = mem_wdata;
      h_we   = mem_we;
    end
  end

  function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] ej(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] v);
    dmem[a[11:2]] = v;
    mmem[a[11:2]] = v;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      dmem[i] = 32'd0;
      mmem[i] = 32'd0;
    end
  endtask

  function automatic logic [31:0] rr(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : mr[r];
  endfunction

  task automatic wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) mr[r] = v;
  endtask

  // Instruction-level model: architectural effect plus expected cycle count.
  task automatic model_step(input int w, output int cyc, output bit etrap, output bit st,
                            output logic [31:0] sa, output logic [31:0] sd);
    logic [31:0] ins, a, b, se, npc, ad, v;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    int          fw;
    ins = mmem[mpc[11:2]];
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
    se = {{16{ins[15]}}, ins[15:0]};
    a = rr(rs); b = rr(rt);
    npc = mpc + 32'd4;
    fw = 1 + w;
    etrap = 1'b0; st = 1'b0; sa = 32'd0; sd = 32'd0; v = 32'd0;
    cyc = fw + 2;
    ad = a + se;
    case (op)
      6'h00: begin
        cyc = fw + 3;
        case (fn)
          6'h20: v = a + b;
          6'h22: v = a - b;
          6'h24: v = a & b;
          6'h25: v = a | b;
          6'h2A: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: begin etrap = 1'b1; cyc = fw + 2; end
        endcase
        if (!etrap) wr(rd, v);
      end
      6'h08: begin cyc = fw + 3; wr(rt, ad); end
      6'h23: begin
        cyc = fw + 3;
        if (ad[1:0] != 2'b00) etrap = 1'b1;
        else begin wr(rt, mmem[ad[11:2]]); cyc = 2 * fw + 3; end
      end
      6'h2B: begin
        cyc = fw + 3;
        if (ad[1:0] != 2'b00) etrap = 1'b1;
        else begin mmem[ad[11:2]] = b; st = 1'b1; sa = ad; sd = b; cyc = 2 * fw + 2; end
      end
      6'h04: if (a == b) npc = npc + (se << 2);
      6'h05: if (a != b) npc = npc + (se << 2);
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      6'h03: begin wr(5'd31, npc); npc = {npc[31:28], ins[25:0], 2'b00}; end
      default: etrap = 1'b1;
    endcase
    mpc = etrap ? mpc + 32'd4 : npc;
  endtask

  // Run one instruction on DUT and model with w wait states per transfer.
  task automatic run_instr(input int w);
    int          cyc, n, we_cnt;
    bit          etrap, st;
    logic [31:0] sa, sd;
    wait_cfg = w;
    model_step(w, cyc, etrap, st, sa, sd);
    n = 0;
    we_cnt = 0;
    while (n < 60) begin
      @(negedge clk);
      #1;
      n++;
      if (mem_req && mem_we) begin
        we_cnt++;
        if (st) begin
          chk("st_addr", mem_addr, sa);
          chk("st_data", mem_wdata, sd);
        end else begin
          chk("unexpected_we", 32'(mem_we), 32'd0);
        end
      end
      if (retire || trap) break;
    end
    if (retire) n_ret++;
    chk("trap", 32'(trap), 32'(etrap));
    chk("retire", 32'(retire), 32'(!etrap));
    chk("cycles", 32'(n), 32'(cyc));
    if (st) chk("we_cycles", 32'(we_cnt), 32'(w + 1));
    if (!etrap) begin
      @(posedge clk);
      #1;
    end
    chk("pc", pc_dbg, mpc);
    last_cyc = n;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mr[i] = 32'd0;
    mpc = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_pc", pc_dbg, 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          tot;
    int          nreq;
    int          k;
    int          kind;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  fns [0:4];
    logic [31:0] da;
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;

    // Arithmetic sequence, then store/load with three wait states.
    clear_mem();
    put(32'h00, ei(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h04, ei(6'h08, 5'd0, 5'd2, 16'd7));
    put(32'h08, er(5'd1, 5'd2, 5'd3, 6'h20));
    put(32'h0C, ei(6'h2B, 5'd0, 5'd3, 16'h0040));
    put(32'h10, ei(6'h23, 5'd0, 5'd4, 16'h0040));
    put(32'h14, ei(6'h2B, 5'd0, 5'd4, 16'h0044));
    do_reset();
    tot = 0;
    n_ret = 0;
    for (int i = 0; i < 3; i++) begin
      run_instr(0);
      tot += last_cyc;
    end
    chk("t1_cycles", 32'(tot), 32'd12);
    chk("t1_retires", 32'(n_ret), 32'd3);
    chk("t1_pc", pc_dbg, 32'h0C);
    run_instr(3);
    run_instr(3);
    run_instr(0);
    chk("t2_sw_mem", dmem[16], 32'd12);
    chk("t2_lw_r4", dmem[17], 32'd12);

    // Branches, jal, slt and r0 write suppression.
    clear_mem();
    put(32'h00, ei(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h04, ei(6'h08, 5'd0, 5'd2, 16'd5));
    put(32'h08, ei(6'h08, 5'd0, 5'd0, 16'd0));
    put(32'h0C, ei(6'h08, 5'd0, 5'd0, 16'd0));
    put(32'h10, ei(6'h04, 5'd1, 5'd2, 16'd2));
    put(32'h1C, ei(6'h05, 5'd1, 5'd2, 16'd2));
    put(32'h20, ej(6'h03, 26'h100));
    put(32'h400, ei(6'h08, 5'd0, 5'd6, 16'hFFFF));
    put(32'h404, ei(6'h08, 5'd0, 5'd7, 16'd1));
    put(32'h408, er(5'd6, 5'd7, 5'd5, 6'h2A));
    put(32'h40C, ei(6'h08, 5'd0, 5'd0, 16'd9));
    put(32'h410, ei(6'h2B, 5'd0, 5'd31, 16'h0080));
    put(32'h414, ei(6'h2B, 5'd0, 5'd5, 16'h0084));
    put(32'h418, ei(6'h2B, 5'd0, 5'd0, 16'h0088));
    put(32'h41C, ei(6'h05, 5'd1, 5'd6, 16'd1));
    put(32'h424, ej(6'h02, 26'h10));
    put(32'h88, 32'hDEAD_BEEF);
    do_reset();
    for (int i = 0; i < 4; i++) run_instr(0);
    run_instr(0);
    chk("beq_pc", pc_dbg, 32'h1C);
    chk("beq_cycles", 32'(last_cyc), 32'd3);
    run_instr(0);
    chk("bne_pc", pc_dbg, 32'h20);
    chk("bne_cycles", 32'(last_cyc), 32'd3);
    run_instr(0);
    chk("jal_pc", pc_dbg, 32'h400);
    for (int i = 0; i < 8; i++) run_instr(1);
    chk("bne_taken_pc", pc_dbg, 32'h424);
    run_instr(2);
    chk("j_pc", pc_dbg, 32'h40);
    chk("jal_r31", dmem[32], 32'h24);
    chk("slt_r5", dmem[33], 32'd1);
    chk("r0_zero", dmem[34], 32'd0);

    // Misaligned lw traps without a request; PC freezes.
    clear_mem();
    put(32'h00, ei(6'h23, 5'd0, 5'd1, 16'd2));
    do_reset();
    run_instr(0);
    nreq = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (mem_req) nreq++;
    end
    chk("trap_noreq", 32'(nreq), 32'd0);
    chk("trap_sticky", 32'(trap), 32'd1);
    chk("trap_pc", pc_dbg, 32'h04);

    // Unknown opcode and unknown funct both trap.
    clear_mem();
    put(32'h00, ej(6'h3F, 26'h0));
    do_reset();
    run_instr(1);
    clear_mem();
    put(32'h00, er(5'd1, 5'd2, 5'd3, 6'h3F));
    do_reset();
    run_instr(0);

    // Reset asserted while a load is waiting for ack.
    clear_mem();
    put(32'h00, ei(6'h23, 5'd0, 5'd1, 16'h0040));
    do_reset();
    wait_cfg = 20;
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      #1;
      k++;
      if (mem_req && (mem_addr == 32'h40)) break;
    end
    chk("mrd_addr", mem_addr, 32'h40);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_pc", pc_dbg, 32'h0);

    // Random programs: ALU ops, loads/stores and forward branches.
    for (int pass = 0; pass < 3; pass++) begin
      clear_mem();
      for (int i = 0; i < 64; i++) put(32'h800 + 32'(4 * i), $urandom);
      for (int i = 0; i < 200; i++) begin
        kind = $urandom_range(0, 5);
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        da = 32'h800 + 32'(4 * $urandom_range(0, 63));
        case (kind)
          0, 1: put(32'(4 * i), ei(6'h08, rs, rt, 16'($urandom)));
          2: put(32'(4 * i), er(rs, rt, rd, fns[$urandom_range(0, 4)]));
          3: put(32'(4 * i), ei(6'h2B, 5'd0, rt, da[15:0]));
          4: put(32'(4 * i), ei(6'h23, 5'd0, rt, da[15:0]));
          default: put(32'(4 * i), ei(($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05,
                                      rs, rt, 16'($urandom_range(0, 2))));
        endcase
      end
      do_reset();
      for (int i = 0; i < 60; i++) run_instr($urandom_range(0, 2));
      for (int i = 512; i < 576; i++) chk("rand_mem", dmem[i], mmem[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
